// File: rtl/lockstep_pkg.sv
// Shared definitions for the lockstep configuration initiator: register address,
// sequencer states and error codes.
package lockstep_pkg;

    localparam logic [31:0] LOCKSTEP_ADDRESS = 32'h1020_2400;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrRsp,
        StRdReq,
        StRdRsp
    } lockstep_init_state_e;

    typedef enum logic [1:0] {
        ErrNone     = 2'b00,
        ErrMismatch = 2'b01,
        ErrOpc      = 2'b10,
        ErrTimeout  = 2'b11
    } lockstep_err_e;

endpackage

// File: rtl/lockstep_timeout_cnt.sv
// Per-state watchdog: counts cycles while enabled, expires on the last allowed cycle.
module lockstep_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && (cnt_q != WIDTH'(TIMEOUT_CYCLES))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // cnt_q holds the number of cycles already spent, so this is the TIMEOUT_CYCLES-th one
    assign expired_o = enable_i && (cnt_q == WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lockstep_cfg_initiator.sv
// Bus initiator that writes a mode word to the lockstep control register and
// optionally reads it back to confirm the value stuck.
module lockstep_cfg_initiator
    import lockstep_pkg::*;
#(
    parameter int unsigned ID_WIDTH       = 5,
    parameter logic [31:0] TARGET_ADDR    = LOCKSTEP_ADDRESS,
    parameter int unsigned MASTER_ID      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter bit          VERIFY         = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    input  logic [31:0]         cmd_mode_i,
    output logic                cmd_ready_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [1:0]          err_code_o,
    output logic                req_o,
    output logic [31:0]         addr_o,
    output logic                wen_o,
    output logic [31:0]         wdata_o,
    output logic [3:0]          be_o,
    output logic [ID_WIDTH-1:0] id_o,
    input  logic                gnt_i,
    input  logic                r_valid_i,
    input  logic                r_opc_i,
    input  logic [ID_WIDTH-1:0] r_id_i,
    input  logic [31:0]         r_rdata_i
);

    lockstep_init_state_e state_q;
    lockstep_err_e        err_code_q;
    logic [31:0]          mode_q;
    logic                 done_q;
    logic                 err_q;

    logic rsp_match;
    logic in_txn;
    logic advance;
    logic expired;
    logic timeout;

    assign rsp_match = r_valid_i && (r_id_i == ID_WIDTH'(MASTER_ID));
    assign in_txn    = (state_q != StIdle);

    always_comb begin
        advance = 1'b0;
        unique case (state_q)
            StWrReq, StRdReq: advance = gnt_i;
            StWrRsp, StRdRsp: advance = rsp_match;
            default:          advance = 1'b0;
        endcase
    end

    lockstep_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (advance || !in_txn),
        .enable_i  (in_txn),
        .expired_o (expired)
    );

    // Progress on the expiry cycle takes priority over the timeout
    assign timeout = expired && !advance;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            mode_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (timeout) begin
                state_q    <= StIdle;
                err_q      <= 1'b1;
                err_code_q <= ErrTimeout;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (cmd_valid_i) begin
                            mode_q     <= cmd_mode_i;
                            err_code_q <= ErrNone;
                            state_q    <= StWrReq;
                        end
                    end
                    StWrReq: if (gnt_i) state_q <= StWrRsp;
                    StWrRsp: begin
                        if (rsp_match) begin
                            if (r_opc_i) begin
                                state_q    <= StIdle;
                                err_q      <= 1'b1;
                                err_code_q <= ErrOpc;
                            end else if (VERIFY) begin
                                state_q <= StRdReq;
                            end else begin
                                state_q <= StIdle;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    StRdReq: if (gnt_i) state_q <= StRdRsp;
                    StRdRsp: begin
                        if (rsp_match) begin
                            state_q <= StIdle;
                            if (r_opc_i) begin
                                err_q      <= 1'b1;
                                err_code_q <= ErrOpc;
                            end else if (r_rdata_i == mode_q) begin
                                done_q <= 1'b1;
                            end else begin
                                err_q      <= 1'b1;
                                err_code_q <= ErrMismatch;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign req_o       = (state_q == StWrReq) || (state_q == StRdReq);
    assign addr_o      = req_o ? TARGET_ADDR : 32'h0;
    assign wen_o       = (state_q == StRdReq);
    assign wdata_o     = mode_q;
    assign be_o        = req_o ? 4'hF : 4'h0;
    assign id_o        = ID_WIDTH'(MASTER_ID);
    assign busy_o      = in_txn;
    assign cmd_ready_o = !in_txn;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;

endmodule
